// File: rtl/comlock_pkg.sv
// Shared constants and key-event types for the digital lock front end,
// controller and display decoder.
package comlock_pkg;

   localparam int unsigned DIGITS  = 4;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned CODE_W  = DIGITS * DIGIT_W;
   localparam logic [CODE_W-1:0] DEFAULT_CODE = 16'h1234;

   // What the entry buffer does in a given cycle, after key priority is applied.
   typedef enum logic [2:0] {
      EV_NONE,
      EV_DIGIT,
      EV_CLEAR,
      EV_ENTER,
      EV_CHANGE,
      EV_INVALID,
      EV_TIMEOUT
   } key_event_e;

   // CLEAR beats ENTER/CHANGE, which beat a digit; the idle timeout only acts
   // when no key is pressed at all.
   function automatic key_event_e decode_key(input logic clear,
                                             input logic enter,
                                             input logic change,
                                             input logic valid,
                                             input logic expired);
      key_event_e ev;
      ev = EV_NONE;
      if (clear)                ev = EV_CLEAR;
      else if (enter && change) ev = EV_INVALID;
      else if (enter)           ev = EV_ENTER;
      else if (change)          ev = EV_CHANGE;
      else if (valid)           ev = EV_DIGIT;
      else if (expired)         ev = EV_TIMEOUT;
      return ev;
   endfunction

endpackage

// File: rtl/code_entry_if.sv
// Keypad / lock-controller side bus of the code entry block.
interface code_entry_if #(
   parameter int unsigned DIGITS  = comlock_pkg::DIGITS,
   parameter int unsigned DIGIT_W = comlock_pkg::DIGIT_W
);

   localparam int unsigned CNT_W = $clog2(DIGITS + 1);

   logic               key_valid;
   logic [DIGIT_W-1:0] key_digit;
   logic               key_enter;
   logic               key_change;
   logic               key_clear;
   logic               load;
   logic               compare;
   logic               enter;
   logic               change;
   logic [CNT_W-1:0]   digit_count;
   logic               entry_full;

   modport master (
      output key_valid, key_digit, key_enter, key_change, key_clear, load,
      input  compare, enter, change, digit_count, entry_full
   );

   modport slave (
      input  key_valid, key_digit, key_enter, key_change, key_clear, load,
      output compare, enter, change, digit_count, entry_full
   );

endinterface

// File: rtl/code_idle_timer.sv
// Idle counter: runs while enabled and not kicked, pulses expired on the
// cycle it would reach TIMEOUT and wraps back to zero.
module code_idle_timer #(
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic clock,
   input  logic reset,
   input  logic kick,
   input  logic enable,
   output logic expired
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0] cnt;

   // Expiry fires on the idle cycle whose increment would hit TIMEOUT.
   always_comb begin
      expired = enable && !kick && (cnt == TW'(TIMEOUT - 1));
   end

   // Counter register: cleared by reset, a key, an empty buffer or expiry.
   always_ff @(posedge clock) begin
      if (reset || kick || !enable || expired) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + TW'(1);
      end
   end

endmodule

// File: rtl/code_entry.sv
// Keypad digit collector for the digital lock: entry buffer, latched entry,
// stored combination, comparator and registered ENTER/CHANGE pulses.
module code_entry #(
   parameter int unsigned DIGITS  = comlock_pkg::DIGITS,
   parameter int unsigned DIGIT_W = comlock_pkg::DIGIT_W,
   parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = comlock_pkg::DEFAULT_CODE,
   parameter int unsigned TIMEOUT = 1000
) (
   input logic        clock,
   input logic        reset,
   code_entry_if.slave bus
);

   import comlock_pkg::*;

   localparam int unsigned ENTRY_W = DIGITS * DIGIT_W;
   localparam int unsigned CNT_W   = $clog2(DIGITS + 1);

   logic [ENTRY_W-1:0] buffer;
   logic [ENTRY_W-1:0] latched;
   logic [ENTRY_W-1:0] stored;
   logic [CNT_W-1:0]   count;
   logic               latched_full;
   logic               enter_q;
   logic               change_q;
   logic               compare_q;
   logic               full;
   logic               match;
   logic               kick;
   logic               expired;
   key_event_e         ev;

   // Any key strobe restarts the idle timer, even one that loses on priority.
   assign kick = bus.key_valid | bus.key_enter | bus.key_change | bus.key_clear;

   code_idle_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_idle_timer (
      .clock  (clock),
      .reset  (reset),
      .kick   (kick),
      .enable (count != '0),
      .expired(expired)
   );

   // Decode this cycle's key action and evaluate the comparator.
   always_comb begin
      full  = (count == CNT_W'(DIGITS));
      match = full && (buffer == stored);
      ev    = decode_key(bus.key_clear, bus.key_enter, bus.key_change,
                         bus.key_valid, expired);
   end

   // Entry buffer, latched/stored codes and one-cycle output pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         buffer       <= '0;
         latched      <= '0;
         stored       <= DEFAULT_CODE;
         count        <= '0;
         latched_full <= 1'b0;
         enter_q      <= 1'b0;
         change_q     <= 1'b0;
         compare_q    <= 1'b0;
      end else begin
         enter_q   <= 1'b0;
         change_q  <= 1'b0;
         compare_q <= 1'b0;

         // Load commits the previous latched entry; a same-cycle ENTER/CHANGE
         // below then re-latches and its latched_full assignment wins.
         if (bus.load) begin
            if (latched_full) begin
               stored <= latched;
            end
            latched_full <= 1'b0;
         end

         unique case (ev)
            EV_DIGIT: begin
               if (!full) begin
                  buffer <= (buffer << DIGIT_W) | ENTRY_W'(bus.key_digit);
                  count  <= count + CNT_W'(1);
               end
            end
            EV_CLEAR, EV_INVALID, EV_TIMEOUT: begin
               buffer <= '0;
               count  <= '0;
            end
            EV_ENTER, EV_CHANGE: begin
               enter_q      <= (ev == EV_ENTER);
               change_q     <= (ev == EV_CHANGE);
               compare_q    <= match;
               latched      <= buffer;
               latched_full <= full;
               buffer       <= '0;
               count        <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.enter       = enter_q;
   assign bus.change      = change_q;
   assign bus.compare     = compare_q;
   assign bus.digit_count = count;
   assign bus.entry_full  = full;

endmodule

// File: tb/tb_code_entry.sv
// Scoreboard bench for code_entry: a digit-queue reference model predicts
// each cycle's outputs, a negedge monitor pops and compares them.
module tb_code_entry;

   localparam int unsigned TMO = 5;

   logic clk;
   logic rst;

   code_entry_if #(.DIGITS(4), .DIGIT_W(4)) bus ();

   code_entry #(
      .DIGITS      (4),
      .DIGIT_W     (4),
      .DEFAULT_CODE(16'h1234),
      .TIMEOUT     (TMO)
   ) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus.slave)
   );

   typedef struct {
      int count;
      bit en;
      bit ch;
      bit cmp;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state: digits in entry order (index 0 = first typed)
   int buf_m[$];
   int stored_m[4];
   int latched_m[4];
   bit lfull_m;
   int idle_m;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input bit r, input bit v, input int d, input bit en,
                       input bit ch, input bit cl, input bit ld);
      exp_t e;
      int   n_stored[4];
      bit   n_lfull;
      int   old_size;
      bit   any;
      bit   ok;
      rst            = r;
      bus.key_valid  = v;
      bus.key_digit  = 4'(d);
      bus.key_enter  = en;
      bus.key_change = ch;
      bus.key_clear  = cl;
      bus.load       = ld;
      e.en = 0; e.ch = 0; e.cmp = 0; e.count = 0;
      if (r) begin
         buf_m.delete();
         stored_m = '{1, 2, 3, 4};
         latched_m = '{0, 0, 0, 0};
         lfull_m = 0;
         idle_m = 0;
      end else begin
         old_size = buf_m.size();
         any = v | en | ch | cl;
         n_stored = stored_m;
         n_lfull = lfull_m;
         if (ld) begin
            if (lfull_m) n_stored = latched_m;
            n_lfull = 0;
         end
         if (cl || (en && ch)) begin
            buf_m.delete();
         end else if (en || ch) begin
            ok = (buf_m.size() == 4);
            e.en = en;
            e.ch = ch;
            e.cmp = ok;
            if (ok) begin
               for (int i = 0; i < 4; i++) begin
                  if (buf_m[i] != stored_m[i]) e.cmp = 0;
                  latched_m[i] = buf_m[i];
               end
            end
            n_lfull = ok;
            buf_m.delete();
         end else if (v) begin
            if (buf_m.size() < 4) buf_m.push_back(d & 15);
         end else if (old_size == 0) begin
            idle_m = 0;
         end else begin
            idle_m++;
            if (idle_m == TMO) begin
               buf_m.delete();
               idle_m = 0;
            end
         end
         if (any) idle_m = 0;
         stored_m = n_stored;
         lfull_m = n_lfull;
      end
      e.count = buf_m.size();
      @(posedge clk);
      #1;
      exp_q.push_back(e);
   endtask

   task automatic dig(input int d);  step(0, 1, d, 0, 0, 0, 0); endtask
   task automatic ent();             step(0, 0, 0, 1, 0, 0, 0); endtask
   task automatic chg();             step(0, 0, 0, 0, 1, 0, 0); endtask
   task automatic ld();              step(0, 0, 0, 0, 0, 0, 1); endtask
   task automatic rst_k();           step(1, 0, 0, 0, 0, 0, 0); endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic code(input int a, input int b, input int c, input int d);
      dig(a); dig(b); dig(c); dig(d);
   endtask

   // Monitor: every cycle the DUT presents count/full/pulse state; compare it.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (bus.digit_count !== 3'(e.count)) begin
            errors++;
            $display("FAIL digit_count t=%0t: got %0d expected %0d", $time, bus.digit_count, e.count);
         end
         checks++;
         if (bus.entry_full !== (e.count == 4)) begin
            errors++;
            $display("FAIL entry_full t=%0t: got %b expected %b", $time, bus.entry_full, e.count == 4);
         end
         checks++;
         if ({bus.enter, bus.change, bus.compare} !== {e.en, e.ch, e.cmp}) begin
            errors++;
            $display("FAIL pulses t=%0t: got enter/change/compare=%b%b%b expected %b%b%b",
                     $time, bus.enter, bus.change, bus.compare, e.en, e.ch, e.cmp);
         end
      end
   end

   initial begin
      int r;
      rst = 1'b1;
      bus.key_valid = 0; bus.key_digit = '0; bus.key_enter = 0;
      bus.key_change = 0; bus.key_clear = 0; bus.load = 0;

      rst_k(); rst_k();
      // correct default code
      code(1, 2, 3, 4); ent(); idle(1);
      // partial entry, then overfull entry with CHANGE
      dig(1); dig(2); dig(3); ent();
      code(1, 2, 3, 4); dig(5); chg(); idle(2);
      // change code to 9876
      code(9, 8, 7, 6); chg(); idle(3); ld(); idle(1);
      code(9, 8, 7, 6); ent();
      code(1, 2, 3, 4); ent(); idle(1);
      // partial change must not load
      rst_k();
      dig(1); dig(2); chg(); ld();
      code(1, 2, 3, 4); ent(); idle(1);
      // idle timeout, and a digit arriving exactly at the expiry cycle
      dig(1); dig(2); idle(5);
      dig(3); dig(4); ent();
      dig(1); idle(TMO - 1); dig(2); idle(1);
      // simultaneous strobes
      code(1, 2, 3, 4); step(0, 0, 0, 1, 1, 0, 0);
      code(1, 2, 3, 4); step(0, 1, 7, 1, 0, 1, 0);
      code(1, 2, 3, 4); step(0, 0, 0, 0, 1, 0, 1); idle(1);
      // load coinciding with ENTER compares against the old stored code
      code(5, 6, 7, 8); chg(); idle(1);
      code(1, 2, 3, 4); step(0, 0, 0, 1, 0, 0, 1);
      code(5, 6, 7, 8); ent();
      // reset during a pulse cycle restores defaults
      code(5, 6, 7, 8); ent(); rst_k();
      code(1, 2, 3, 4); ent(); idle(1);

      for (int n = 0; n < 1500; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 6)       begin code(stored_m[0], stored_m[1], stored_m[2], stored_m[3]);
                                step(0, 0, 0, r < 3, r >= 3, 0, 0); end
         else if (r < 40) dig(int'($urandom_range(0, 9)));
         else if (r < 48) ent();
         else if (r < 55) chg();
         else if (r < 58) step(0, 0, 0, 0, 0, 1, 0);
         else if (r < 60) step(0, 0, 0, 1, 1, 0, 0);
         else if (r < 62) step(0, 1, 3, 1, 0, 1, 0);
         else if (r < 67) ld();
         else if (r < 70) step(0, 1, int'($urandom_range(0, 9)), 0, 0, 0, 1);
         else if (r < 72) step(0, 0, 0, 0, 1, 0, 1);
         else if (r == 99) rst_k();
         else             idle(1);
      end

      idle(2);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
